// File: rtl/mask_unit_xbar_pkg.sv
// rtl/mask_unit_xbar_pkg.sv - shared widths, helpers and request types for the mask-unit read crossbar
package mask_unit_xbar_pkg;

    localparam int DEF_INPUTS   = 4;
    localparam int DEF_LANES    = 4;
    localparam int DEF_VS_W     = 5;
    localparam int DEF_OFFSET_W = 5;
    localparam int DEF_DOFF_W   = 2;

    // Index width that never collapses to zero bits, even for a single-entry range.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_LANE_W = clog2_min1(DEF_LANES);
    localparam int DEF_IDX_W  = clog2_min1(DEF_INPUTS);

    typedef struct packed {
        logic [DEF_VS_W-1:0]     vs;
        logic [DEF_OFFSET_W-1:0] offset;
        logic [DEF_LANE_W-1:0]   readLane;
        logic [DEF_DOFF_W-1:0]   dataOffset;
    } read_req_t;

    typedef struct packed {
        logic [DEF_VS_W-1:0]     vs;
        logic [DEF_OFFSET_W-1:0] offset;
        logic [DEF_IDX_W-1:0]    writeIndex;
        logic [DEF_DOFF_W-1:0]   dataOffset;
    } lane_req_t;

endpackage

// File: rtl/mask_unit_read_crossbar_rr_arbiter.sv
// rtl/mask_unit_read_crossbar_rr_arbiter.sv - cyclic priority arbiter: first request at or after ptr wins
module rr_arbiter
    import mask_unit_xbar_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grantIdx,
    output logic             anyGrant
);

    logic [IDX_W-1:0] hiIdx;
    logic [IDX_W-1:0] loIdx;
    logic             hiFound;
    logic             loFound;

    // Lowest requester at or above ptr takes precedence; otherwise wrap to the lowest overall.
    always_comb begin
        hiIdx   = '0;
        loIdx   = '0;
        hiFound = 1'b0;
        loFound = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                loIdx   = IDX_W'(i);
                loFound = 1'b1;
                if (IDX_W'(i) >= ptr) begin
                    hiIdx   = IDX_W'(i);
                    hiFound = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grantIdx = hiFound ? hiIdx : loIdx;
        anyGrant = loFound;
        grant    = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = anyGrant && (grantIdx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/mask_unit_read_crossbar_rr.sv
// rtl/mask_unit_read_crossbar_rr.sv - registered round-robin crossbar from mask-unit read requesters to lane read ports
module mask_unit_read_crossbar_rr
    import mask_unit_xbar_pkg::*;
#(
    parameter int INPUTS   = DEF_INPUTS,
    parameter int LANES    = DEF_LANES,
    parameter int VS_W     = DEF_VS_W,
    parameter int OFFSET_W = DEF_OFFSET_W,
    parameter int DOFF_W   = DEF_DOFF_W,
    parameter int LANE_W   = clog2_min1(LANES),
    parameter int IDX_W    = clog2_min1(INPUTS)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [INPUTS-1:0]          in_valid,
    output logic [INPUTS-1:0]          in_ready,
    input  logic [INPUTS*VS_W-1:0]     in_vs,
    input  logic [INPUTS*OFFSET_W-1:0] in_offset,
    input  logic [INPUTS*LANE_W-1:0]   in_readLane,
    input  logic [INPUTS*DOFF_W-1:0]   in_dataOffset,
    output logic [LANES-1:0]           out_valid,
    input  logic [LANES-1:0]           out_ready,
    output logic [LANES*VS_W-1:0]      out_vs,
    output logic [LANES*OFFSET_W-1:0]  out_offset,
    output logic [LANES*IDX_W-1:0]     out_writeIndex,
    output logic [LANES*DOFF_W-1:0]    out_dataOffset,
    output logic                       out_busy
);

    logic [VS_W-1:0]     inVs     [INPUTS];
    logic [OFFSET_W-1:0] inOffset [INPUTS];
    logic [LANE_W-1:0]   inLane   [INPUTS];
    logic [DOFF_W-1:0]   inDoff   [INPUTS];

    logic [INPUTS-1:0]   laneReq   [LANES];
    logic [INPUTS-1:0]   laneGrant [LANES];
    logic [IDX_W-1:0]    grantIdx  [LANES];
    logic [LANES-1:0]    anyGrant;
    logic [LANES-1:0]    slotFree;
    logic [LANES-1:0]    fire;

    logic [VS_W-1:0]     selVs     [LANES];
    logic [OFFSET_W-1:0] selOffset [LANES];
    logic [DOFF_W-1:0]   selDoff   [LANES];

    logic [LANES-1:0]    outValidQ;
    logic [VS_W-1:0]     outVsQ     [LANES];
    logic [OFFSET_W-1:0] outOffsetQ [LANES];
    logic [IDX_W-1:0]    outIdxQ    [LANES];
    logic [DOFF_W-1:0]   outDoffQ   [LANES];
    logic [IDX_W-1:0]    ptrQ       [LANES];

    always_comb begin
        for (int i = 0; i < INPUTS; i++) begin
            inVs[i]     = in_vs[i*VS_W +: VS_W];
            inOffset[i] = in_offset[i*OFFSET_W +: OFFSET_W];
            inLane[i]   = in_readLane[i*LANE_W +: LANE_W];
            inDoff[i]   = in_dataOffset[i*DOFF_W +: DOFF_W];
        end
    end

    // A readLane beyond LANES-1 matches no lane, so such a request simply never gets ready.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            laneReq[l] = '0;
            for (int i = 0; i < INPUTS; i++) begin
                laneReq[l][i] = in_valid[i] && (inLane[i] == LANE_W'(l));
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        rr_arbiter #(
            .N     (INPUTS),
            .IDX_W (IDX_W)
        ) u_arb (
            .req      (laneReq[l]),
            .ptr      (ptrQ[l]),
            .grant    (laneGrant[l]),
            .grantIdx (grantIdx[l]),
            .anyGrant (anyGrant[l])
        );
    end

    always_comb begin
        in_ready = '0;
        for (int l = 0; l < LANES; l++) begin
            slotFree[l]  = !outValidQ[l] || out_ready[l];
            fire[l]      = anyGrant[l] && slotFree[l] && !reset;
            selVs[l]     = '0;
            selOffset[l] = '0;
            selDoff[l]   = '0;
            for (int i = 0; i < INPUTS; i++) begin
                if (laneGrant[l][i]) begin
                    selVs[l]     = inVs[i];
                    selOffset[l] = inOffset[i];
                    selDoff[l]   = inDoff[i];
                end
            end
            if (slotFree[l] && !reset) begin
                in_ready = in_ready | laneGrant[l];
            end
        end
    end

    // Fill wins over drain, which is what lets a lane refill in the cycle it empties.
    always_ff @(posedge clock) begin
        if (reset) begin
            outValidQ <= '0;
            for (int l = 0; l < LANES; l++) begin
                outVsQ[l]     <= '0;
                outOffsetQ[l] <= '0;
                outIdxQ[l]    <= '0;
                outDoffQ[l]   <= '0;
                ptrQ[l]       <= '0;
            end
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (fire[l]) begin
                    outValidQ[l]  <= 1'b1;
                    outVsQ[l]     <= selVs[l];
                    outOffsetQ[l] <= selOffset[l];
                    outIdxQ[l]    <= grantIdx[l];
                    outDoffQ[l]   <= selDoff[l];
                    ptrQ[l]       <= (grantIdx[l] == IDX_W'(INPUTS - 1)) ? '0
                                                                        : grantIdx[l] + IDX_W'(1);
                end else if (out_ready[l]) begin
                    outValidQ[l] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        out_valid = outValidQ;
        out_busy  = |outValidQ;
        for (int l = 0; l < LANES; l++) begin
            out_vs[l*VS_W +: VS_W]               = outVsQ[l];
            out_offset[l*OFFSET_W +: OFFSET_W]   = outOffsetQ[l];
            out_writeIndex[l*IDX_W +: IDX_W]     = outIdxQ[l];
            out_dataOffset[l*DOFF_W +: DOFF_W]   = outDoffQ[l];
        end
    end

endmodule

// File: tb/tb_mask_unit_read_crossbar_rr.sv
// tb/tb_mask_unit_read_crossbar_rr.sv - randomized and directed bench against a queue-free reference model
module tb_mask_unit_read_crossbar_rr;

    localparam int NI = 4, NL = 4, VW = 5, OW = 5, DW = 2, LW = 2, IW = 2, NL3 = 3;

    logic clock = 1'b0;
    logic rst;
    always #5 clock = ~clock;

    logic [NI-1:0]    inValid, inReady;
    logic [NI*VW-1:0] inVs;
    logic [NI*OW-1:0] inOffset;
    logic [NI*LW-1:0] inLane;
    logic [NI*DW-1:0] inDoff;
    logic [NL-1:0]    outValid, outReady;
    logic [NL*VW-1:0] outVs;
    logic [NL*OW-1:0] outOffset;
    logic [NL*IW-1:0] outWi;
    logic [NL*DW-1:0] outDoff;
    logic             outBusy;

    logic [NI-1:0]     inValid3, inReady3;
    logic [NI*LW-1:0]  inLane3;
    logic [NL3-1:0]    outValid3, outReady3;
    logic [NL3*VW-1:0] outVs3;
    logic [NL3*OW-1:0] outOffset3;
    logic [NL3*IW-1:0] outWi3;
    logic [NL3*DW-1:0] outDoff3;
    logic              outBusy3;

    mask_unit_read_crossbar_rr #(.INPUTS(NI), .LANES(NL)) dut (
        .clock(clock), .reset(rst), .in_valid(inValid), .in_ready(inReady), .in_vs(inVs),
        .in_offset(inOffset), .in_readLane(inLane), .in_dataOffset(inDoff),
        .out_valid(outValid), .out_ready(outReady), .out_vs(outVs), .out_offset(outOffset),
        .out_writeIndex(outWi), .out_dataOffset(outDoff), .out_busy(outBusy)
    );

    mask_unit_read_crossbar_rr #(.INPUTS(NI), .LANES(NL3)) dut3 (
        .clock(clock), .reset(rst), .in_valid(inValid3), .in_ready(inReady3), .in_vs(inVs),
        .in_offset(inOffset), .in_readLane(inLane3), .in_dataOffset(inDoff),
        .out_valid(outValid3), .out_ready(outReady3), .out_vs(outVs3), .out_offset(outOffset3),
        .out_writeIndex(outWi3), .out_dataOffset(outDoff3), .out_busy(outBusy3)
    );

    int passCnt = 0, totalCnt = 0;
    int sValid[NI], sVs[NI], sOff[NI], sLane[NI], sDoff[NI], sReady[NL];
    int mValid[NL], mVs[NL], mOff[NL], mIdx[NL], mDoff[NL], mPtr[NL];
    int gnt[NL], eReady[NI];

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        totalCnt++;
        if (got === exp) passCnt++;
        else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic applyInputs();
        for (int i = 0; i < NI; i++) begin
            inValid[i]           = sValid[i][0];
            inVs[i*VW +: VW]     = VW'(sVs[i]);
            inOffset[i*OW +: OW] = OW'(sOff[i]);
            inLane[i*LW +: LW]   = LW'(sLane[i]);
            inDoff[i*DW +: DW]   = DW'(sDoff[i]);
        end
        for (int l = 0; l < NL; l++) outReady[l] = sReady[l][0];
    endtask

    task automatic clearStim();
        for (int i = 0; i < NI; i++) begin
            sValid[i] = 0; sVs[i] = 0; sOff[i] = 0; sLane[i] = 0; sDoff[i] = 0;
        end
        for (int l = 0; l < NL; l++) sReady[l] = 1;
    endtask

    // Winner per lane = requester with the smallest cyclic distance from that lane's pointer.
    task automatic modelEval();
        for (int i = 0; i < NI; i++) eReady[i] = 0;
        for (int l = 0; l < NL; l++) begin
            int best;
            best   = NI;
            gnt[l] = -1;
            if (!rst && (mValid[l] == 0 || sReady[l] != 0)) begin
                for (int i = 0; i < NI; i++) begin
                    if (sValid[i] != 0 && sLane[i] == l && (i - mPtr[l] + NI) % NI < best) begin
                        best   = (i - mPtr[l] + NI) % NI;
                        gnt[l] = i;
                    end
                end
            end
            if (gnt[l] >= 0) eReady[gnt[l]] = 1;
        end
    endtask

    task automatic modelUpdate();
        for (int l = 0; l < NL; l++) begin
            if (rst) begin
                mValid[l] = 0; mPtr[l] = 0;
            end else if (gnt[l] >= 0) begin
                mValid[l] = 1; mVs[l] = sVs[gnt[l]]; mOff[l] = sOff[gnt[l]];
                mIdx[l] = gnt[l]; mDoff[l] = sDoff[gnt[l]]; mPtr[l] = (gnt[l] + 1) % NI;
            end else if (sReady[l] != 0) begin
                mValid[l] = 0;
            end
        end
    endtask

    // Called at a falling edge; compares combinational and registered outputs, then advances one cycle.
    task automatic step(input string tag);
        int busy;
        applyInputs();
        #1;
        modelEval();
        busy = 0;
        for (int i = 0; i < NI; i++) checkVal($sformatf("%s_rdy%0d", tag, i), inReady[i], eReady[i]);
        for (int l = 0; l < NL; l++) begin
            busy |= mValid[l];
            checkVal($sformatf("%s_val%0d", tag, l), outValid[l], mValid[l]);
            if (mValid[l] != 0) begin
                checkVal($sformatf("%s_vs%0d", tag, l), outVs[l*VW +: VW], mVs[l]);
                checkVal($sformatf("%s_off%0d", tag, l), outOffset[l*OW +: OW], mOff[l]);
                checkVal($sformatf("%s_wi%0d", tag, l), outWi[l*IW +: IW], mIdx[l]);
                checkVal($sformatf("%s_doff%0d", tag, l), outDoff[l*DW +: DW], mDoff[l]);
            end
        end
        checkVal({tag, "_busy"}, outBusy, busy);
        @(posedge clock);
        modelUpdate();
        @(negedge clock);
    endtask

    initial begin
        int heldVs;
        int seq[6] = '{0, 1, 3, 0, 1, 3};
        rst = 1'b1;
        clearStim();
        applyInputs();
        inValid3 = '0; inLane3 = '0; outReady3 = '1;
        for (int l = 0; l < NL; l++) begin mValid[l] = 0; mPtr[l] = 0; end
        repeat (2) @(posedge clock);
        @(negedge clock);
        sValid[0] = 1; sLane[0] = 2;
        step("rst");
        checkVal("rst_data", {outVs, outOffset, outWi, outDoff}, 64'd0);
        checkVal("rst_valid3", outValid3, 0);
        rst = 1'b0;
        clearStim();

        sValid[2] = 1; sVs[2] = 7; sOff[2] = 3; sLane[2] = 1; sDoff[2] = 2;
        step("single");
        checkVal("single_valid", outValid, 4'b0010);
        checkVal("single_wi", outWi[1*IW +: IW], 2);
        clearStim();
        step("single_drain");

        for (int i = 0; i < NI; i++) begin
            sValid[i] = (i != 2); sLane[i] = 0; sVs[i] = 20 + i;
        end
        for (int k = 0; k < 6; k++) begin
            step("rr");
            checkVal($sformatf("rr_seq%0d", k), outWi[0 +: IW], seq[k]);
        end
        clearStim();
        step("rr_drain");

        sValid[0] = 1; sLane[0] = 3; sVs[0] = 10; sOff[0] = 4;
        step("bp_fill");
        heldVs = outVs[3*VW +: VW];
        sVs[0] = 11; sValid[1] = 1; sLane[1] = 3; sVs[1] = 12; sReady[3] = 0;
        for (int k = 0; k < 5; k++) begin
            step("bp_hold");
            checkVal("bp_stable", outVs[3*VW +: VW], heldVs);
        end
        sReady[3] = 1;
        step("bp_refill");
        clearStim();
        step("bp_drain");

        for (int i = 0; i < NI; i++) begin
            sValid[i] = 1; sLane[i] = 3 - i; sVs[i] = 30 - i; sDoff[i] = i;
        end
        step("par");
        checkVal("par_valid", outValid, 4'b1111);
        for (int l = 0; l < NL; l++) checkVal($sformatf("par_wi%0d", l), outWi[l*IW +: IW], 3 - l);
        clearStim();
        step("par_drain");

        sValid[1] = 1; sLane[1] = 0;
        step("mid_fill");
        clearStim();
        sReady[0] = 0;
        rst = 1'b1;
        step("mid_rst");
        rst = 1'b0;
        checkVal("mid_rst_valid", outValid, 0);
        sReady[0] = 1;
        for (int i = 0; i < 3; i++) begin sValid[i] = 1; sLane[i] = 0; end
        step("mid_post");
        checkVal("mid_first_grant", outWi[0 +: IW], 0);
        clearStim();

        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NI; i++) begin
                sValid[i] = ($urandom_range(0, 3) != 0);
                sLane[i]  = $urandom_range(0, NL - 1);
                sVs[i]    = $urandom_range(0, 31);
                sOff[i]   = $urandom_range(0, 31);
                sDoff[i]  = $urandom_range(0, 3);
            end
            for (int l = 0; l < NL; l++) sReady[l] = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 49) == 0);
            step("rand");
        end
        rst = 1'b0;
        clearStim();
        applyInputs();

        inVs = {5'd4, 5'd3, 5'd2, 5'd1};
        inValid3 = 4'b0111;
        inLane3  = {2'd0, 2'd0, 2'd2, 2'd3};
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            #1;
            checkVal($sformatf("oor_rdy0_%0d", k), inReady3[0], 0);
            checkVal($sformatf("oor_rdy1_%0d", k), inReady3[1], 1);
            checkVal($sformatf("oor_rdy2_%0d", k), inReady3[2], 1);
            if (k > 0) begin
                checkVal($sformatf("oor_valid_%0d", k), outValid3, 3'b101);
                checkVal($sformatf("oor_wi2_%0d", k), outWi3[2*IW +: IW], 1);
                checkVal($sformatf("oor_wi0_%0d", k), outWi3[0 +: IW], 2);
                checkVal($sformatf("oor_vs0_%0d", k), outVs3[0 +: VW], 3);
            end
        end
        inValid3 = '0;

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
